// File: rtl/hdmi_strip_scheduler.sv
// Frame-level block-fetch sequencer for the HDMI ping-pong strip buffers.
// Issues 8x8 block coordinates in raster order, gating each strip on a free-buffer credit.
module hdmi_strip_scheduler #(
    parameter int X_RES   = 2160,
    parameter int Y_RES   = 1200,
    parameter int BUF_CNT = 2,
    localparam int XB = X_RES / 8,
    localparam int YB = Y_RES / 8,
    localparam int XW = (XB > 1) ? $clog2(XB) : 1,
    localparam int YW = (YB > 1) ? $clog2(YB) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          frame_start,
    input  logic          strip_release,
    output logic          req_valid,
    input  logic          req_ready,
    output logic [XW-1:0] req_blk_x,
    output logic [YW-1:0] req_blk_y,
    output logic          req_sof,
    output logic          req_sos,
    output logic          req_eof,
    output logic [1:0]    credits,
    output logic          busy,
    output logic          frame_done,
    output logic          err_overrun,
    output logic          err_release
);

    typedef enum logic [1:0] {IDLE, WAIT_CREDIT, ISSUE} state_t;

    localparam logic [XW-1:0] X_LAST = XW'(XB - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(YB - 1);
    localparam logic [1:0]    CR_MAX = 2'(BUF_CNT);

    state_t        state_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [1:0]    credits_q, credits_d;
    logic          valid_q, sof_q, sos_q, eof_q;
    logic          busy_q, done_q, err_ovr_q, err_rel_q;

    logic          consume, hs;
    logic [XW-1:0] x_nxt;

    assign consume = (state_q == WAIT_CREDIT) && (credits_q != 2'd0);
    assign hs      = valid_q && req_ready;
    assign x_nxt   = x_q + XW'(1);

    // A release and a consume in the same cycle cancel; a release at full is dropped.
    always_comb begin
        credits_d = credits_q;
        if (consume && !strip_release)
            credits_d = credits_q - 2'd1;
        else if (strip_release && !consume && credits_q != CR_MAX)
            credits_d = credits_q + 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            credits_q <= CR_MAX;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            sos_q     <= 1'b0;
            eof_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_ovr_q <= 1'b0;
            err_rel_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            credits_q <= credits_d;
            if (strip_release && !consume && credits_q == CR_MAX)
                err_rel_q <= 1'b1;
            if (frame_start && state_q != IDLE)
                err_ovr_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (enable && frame_start) begin
                        x_q     <= '0;
                        y_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= WAIT_CREDIT;
                    end
                end
                WAIT_CREDIT: begin
                    if (consume) begin
                        valid_q <= 1'b1;
                        sof_q   <= (x_q == '0) && (y_q == '0);
                        sos_q   <= (x_q == '0);
                        eof_q   <= (x_q == X_LAST) && (y_q == Y_LAST);
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        if (x_q != X_LAST) begin
                            x_q   <= x_nxt;
                            sof_q <= 1'b0;
                            sos_q <= 1'b0;
                            eof_q <= (x_nxt == X_LAST) && (y_q == Y_LAST);
                        end else begin
                            valid_q <= 1'b0;
                            sof_q   <= 1'b0;
                            sos_q   <= 1'b0;
                            eof_q   <= 1'b0;
                            if (y_q != Y_LAST) begin
                                x_q     <= '0;
                                y_q     <= y_q + YW'(1);
                                state_q <= WAIT_CREDIT;
                            end else begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_valid   = valid_q;
    assign req_blk_x   = x_q;
    assign req_blk_y   = y_q;
    assign req_sof     = sof_q;
    assign req_sos     = sos_q;
    assign req_eof     = eof_q;
    assign credits     = credits_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign err_overrun = err_ovr_q;
    assign err_release = err_rel_q;

endmodule

// File: tb/tb_hdmi_strip_scheduler.sv
// Directed bench for hdmi_strip_scheduler on a 32x24 frame (4x3 blocks, 2 strip buffers).
module tb_hdmi_strip_scheduler;
    logic       clk = 0, rst = 1, enable = 0, frame_start = 0, strip_release = 0, req_ready = 1;
    logic       req_valid, req_sof, req_sos, req_eof, busy, frame_done, err_overrun, err_release;
    logic [1:0] req_blk_x, req_blk_y, credits;

    hdmi_strip_scheduler #(.X_RES(32), .Y_RES(24), .BUF_CNT(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
        .strip_release(strip_release), .req_valid(req_valid), .req_ready(req_ready),
        .req_blk_x(req_blk_x), .req_blk_y(req_blk_y), .req_sof(req_sof), .req_sos(req_sos),
        .req_eof(req_eof), .credits(credits), .busy(busy), .frame_done(frame_done),
        .err_overrun(err_overrun), .err_release(err_release)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; bit sof; bit sos; bit eof; } hs_t;
    hs_t hsq[$];
    int  n_chk = 0, n_fail = 0;
    int  cyc = 0, fd_cnt = 0, fd_cyc = 0, last_hs_cyc = 0, rel_cnt = 0;
    bit  auto_rel = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Inputs are set at the negedge; the handshake the next posedge will see is logged here.
    task automatic step();
        hs_t h;
        if (auto_rel) begin
            strip_release = 0;
            if (rel_cnt > 0) begin
                rel_cnt--;
                if (rel_cnt == 0) strip_release = 1;
            end
        end
        if (req_valid && req_ready) begin
            h.x = req_blk_x; h.y = req_blk_y;
            h.sof = req_sof; h.sos = req_sos; h.eof = req_eof;
            hsq.push_back(h);
            last_hs_cyc = cyc;
            if (req_blk_x == 2'd3) rel_cnt = 3;
        end
        @(negedge clk);
        cyc++;
        if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
    endtask

    task automatic start_frame();
        hsq.delete();
        frame_start = 1; step(); frame_start = 0;
    endtask

    task automatic run_to_done(input string tag, input int budget);
        int start;
        start = fd_cnt;
        for (int i = 0; i < budget && fd_cnt == start; i++) step();
        check({tag, "_done"}, fd_cnt - start, 1);
    endtask

    task automatic check_frame(input string p);
        check({p, "_count"}, hsq.size(), 12);
        for (int i = 0; i < hsq.size() && i < 12; i++) begin
            check($sformatf("%s_x%0d", p, i), hsq[i].x, i % 4);
            check($sformatf("%s_y%0d", p, i), hsq[i].y, i / 4);
            check($sformatf("%s_sof%0d", p, i), hsq[i].sof, (i == 0));
            check($sformatf("%s_sos%0d", p, i), hsq[i].sos, (i % 4 == 0));
            check($sformatf("%s_eof%0d", p, i), hsq[i].eof, (i == 11));
        end
    endtask

    task automatic check_reset(input string p);
        check({p, "_valid"}, req_valid, 0);
        check({p, "_x"}, req_blk_x, 0);
        check({p, "_y"}, req_blk_y, 0);
        check({p, "_sof"}, req_sof, 0);
        check({p, "_sos"}, req_sos, 0);
        check({p, "_eof"}, req_eof, 0);
        check({p, "_credits"}, credits, 2);
        check({p, "_busy"}, busy, 0);
        check({p, "_done"}, frame_done, 0);
        check({p, "_err_ovr"}, err_overrun, 0);
        check({p, "_err_rel"}, err_release, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset("rst0");
        rst = 0;
        step();

        // frame_start without enable is ignored silently
        frame_start = 1; step(); frame_start = 0; step();
        check("noen_busy", busy, 0);
        check("noen_err", err_overrun, 0);

        // full frame with releases 3 cycles after each strip end
        enable = 1; auto_rel = 1; rel_cnt = 0;
        start_frame();
        check("lat_wait_busy", busy, 1);
        check("lat_wait_valid", req_valid, 0);
        step();
        check("lat_valid", req_valid, 1);
        check("lat_sof", req_sof, 1);
        run_to_done("ff", 200);
        check("ff_done_cyc", fd_cyc, last_hs_cyc + 1);
        check("ff_busy_drop", busy, 0);
        repeat (5) step();
        check("ff_done_once", fd_cnt, 1);
        check("ff_credits", credits, 2);
        check_frame("ff");

        // credit stall: no releases
        auto_rel = 0; strip_release = 0;
        start_frame();
        repeat (40) step();
        check("stall_count", hsq.size(), 8);
        check("stall_valid", req_valid, 0);
        check("stall_credits", credits, 0);
        check("stall_busy", busy, 1);
        strip_release = 1; step(); strip_release = 0;
        check("stall_rel_credits", credits, 1);
        check("stall_rel_valid", req_valid, 0);
        step();
        check("stall_resume_valid", req_valid, 1);
        check("stall_resume_x", req_blk_x, 0);
        check("stall_resume_y", req_blk_y, 2);
        check("stall_resume_credits", credits, 0);
        run_to_done("stall", 50);
        check_frame("stall");
        strip_release = 1; step(); step(); strip_release = 0; step();
        check("stall_refill", credits, 2);
        check("stall_no_err", err_release, 0);

        // backpressure at (2,1)
        auto_rel = 1; rel_cnt = 0;
        start_frame();
        for (int i = 0; i < 100; i++) begin
            if (req_valid && req_blk_x == 2'd2 && req_blk_y == 2'd1) break;
            step();
        end
        req_ready = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("bp_valid%0d", i), req_valid, 1);
            check($sformatf("bp_x%0d", i), req_blk_x, 2);
            check($sformatf("bp_y%0d", i), req_blk_y, 1);
        end
        check("bp_hs_held", hsq.size(), 6);
        req_ready = 1; step();
        check("bp_hs_count", hsq.size(), 7);
        check("bp_next_x", req_blk_x, 3);
        run_to_done("bp", 100);
        repeat (5) step();
        check("bp_credits", credits, 2);
        check_frame("bp");

        // release coinciding with a consume at credits==1
        auto_rel = 0; strip_release = 0;
        start_frame();
        for (int i = 0; i < 50; i++) begin
            if (req_valid && req_blk_x == 2'd3 && req_blk_y == 2'd0) break;
            step();
        end
        step();
        check("sim_pre_credits", credits, 1);
        check("sim_pre_valid", req_valid, 0);
        strip_release = 1; step(); strip_release = 0;
        check("sim_credits", credits, 1);
        check("sim_valid", req_valid, 1);
        check("sim_y", req_blk_y, 1);
        check("sim_no_err", err_release, 0);
        auto_rel = 1; rel_cnt = 0;
        run_to_done("sim", 100);
        repeat (5) step();
        check("sim_end_credits", credits, 2);
        check_frame("sim");

        // release at full credits in IDLE
        auto_rel = 0; strip_release = 1; step(); strip_release = 0;
        check("relfull_credits", credits, 2);
        check("relfull_err", err_release, 1);
        repeat (3) step();
        check("relfull_sticky", err_release, 1);

        // frame_start during handshake 5
        auto_rel = 1; rel_cnt = 0;
        start_frame();
        for (int i = 0; i < 50; i++) begin
            if (hsq.size() == 4 && req_valid) break;
            step();
        end
        frame_start = 1; step(); frame_start = 0;
        check("ovr_hs5", hsq.size(), 5);
        check("ovr_err", err_overrun, 1);
        check("ovr_busy", busy, 1);
        run_to_done("ovr", 100);
        check_frame("ovr");
        check("ovr_sticky", err_overrun, 1);
        repeat (5) step();

        // asynchronous reset mid-frame drops the outstanding request
        start_frame();
        repeat (3) step();
        check("mid_valid_pre", req_valid, 1);
        #2 rst = 1;
        #1 check_reset("rst_mid");
        @(negedge clk); rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hdmi_strip_scheduler.md
Name: hdmi_strip_scheduler

Overview:
- Frame-level controller that sequences block fetches feeding the HDMI ping-pong strip buffers.
- Emits 8x8 block coordinates in raster order (all blocks of one 8-line strip, then the next strip) to the block fetch engine over a valid/ready request interface.
- Gates each strip on a buffer credit: a strip starts only when a strip buffer is free. The display side returns credits via strip_release when a strip has drained.

Parameters:
- X_RES, 2160, horizontal resolution; multiple of 8.
- Y_RES, 1200, vertical resolution; multiple of 8.
- BUF_CNT, 2, number of strip buffers (initial credits); 1..3.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  arms frame start; sampled only in IDLE.
- frame_start  in  1  one-cycle pulse requesting a new frame.
- strip_release  in  1  one-cycle pulse: one strip buffer drained, return one credit.
- req_valid  out  1  block request valid.
- req_ready  in  1  fetch engine accepts the request.
- req_blk_x  out  clog2(X_RES/8)  block column.
- req_blk_y  out  clog2(Y_RES/8)  strip (block row).
- req_sof  out  1  request is block (0,0).
- req_sos  out  1  request is first block of a strip (x==0).
- req_eof  out  1  request is the last block of the frame.
- credits  out  2  free strip buffers.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse after the last handshake.
- err_overrun  out  1  sticky: frame_start received while busy.
- err_release  out  1  sticky: strip_release received with credits==BUF_CNT.

Behaviour:
- Reset values: req_valid=0, req_blk_x=0, req_blk_y=0, req_sof=0, req_sos=0, req_eof=0, credits=BUF_CNT, busy=0, frame_done=0, err_*=0.
- Reset takes effect immediately when asserted mid-frame; any outstanding request is dropped.
- All outputs are registered.
- Handshake occurs when req_valid && req_ready.
- Once req_valid is asserted, it and all req_* fields stay stable until the handshake.
- FSM states: IDLE, WAIT_CREDIT, ISSUE.
- IDLE:
  - If enable && frame_start: x=0, y=0, go to WAIT_CREDIT.
  - Otherwise stay in IDLE.
- WAIT_CREDIT:
  - If registered credits > 0: decrement credits, go to ISSUE.
  - A strip_release arriving in the same cycle is counted but does not unblock until the next cycle.
- ISSUE:
  - req_valid=1.
  - On handshake with x < X_RES/8-1: x++, stay in ISSUE.
  - On handshake with x == last and y < Y_RES/8-1: x=0, y++, go to WAIT_CREDIT.
  - On handshake with x == last and y == last: go to IDLE; frame_done=1 for one cycle.
- Latency, frame_start to request: frame_start sampled at edge t → WAIT_CREDIT at t+1 → req_valid high from t+2 when a credit is available.
- Latency, strip to strip: the strip's last handshake at edge t → next strip's req_valid at t+2 when a credit is available.
- Flag decode:
  - req_sof = (x==0 && y==0).
  - req_sos = (x==0).
  - req_eof = (x==last && y==last).
- Credit arithmetic:
  - Credits move +1 on strip_release and -1 on WAIT_CREDIT→ISSUE.
  - Both in the same cycle: net 0.
  - Release at credits==BUF_CNT (with no simultaneous consume): credits unchanged, err_release set.
  - Credits never underflow, because consume requires credits > 0.
  - strip_release is honoured in every state, including IDLE.
- frame_start while busy: ignored and err_overrun set.
- frame_start in IDLE with enable=0: ignored, no error.
- enable deasserted mid-frame: the frame completes; no new frame starts.
- Credits persist across frames; frame start does not reset them.

Test Plan:
- Reset: assert rst mid-cycle → all outputs at reset values asynchronously; credits=2.
- Full frame (X_RES=32, Y_RES=24, req_ready=1, strip_release 3 cycles after each strip's last handshake):
  - Exactly 12 handshakes in order (0,0)..(3,0),(0,1)..(3,2).
  - req_sof only on the first; req_sos on 3 requests; req_eof on the last.
  - frame_done pulses once, the cycle after handshake 12; busy then drops.
- Credit stall (same params, no strip_release):
  - 8 handshakes, then req_valid stays 0 with credits=0.
  - Pulse strip_release → req_valid rises 2 cycles later at (0,2).
- Backpressure: hold req_ready=0 for 5 cycles while at (2,1) → req_valid=1 and req_blk_x=2, req_blk_y=1 stable; the handshake completes on the cycle req_ready returns.
- Simultaneous events:
  - strip_release in the same cycle as a WAIT_CREDIT→ISSUE consume with credits=1 → credits stays 1.
  - strip_release with credits=2 in IDLE → credits=2, err_release=1 and held.
- Overrun: frame_start at handshake 5 of a frame → ignored, err_overrun=1, the frame finishes with 12 handshakes total; then assert rst → err_overrun=0.
